// File: rtl/sd_blk_pkg.sv
// Shared types and constants for the SD block FIFO drain path.
// The SD_BLK_CRC16_EN build option uses the CRC constants below.
package sd_blk_pkg;

    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [15:0] CRC16_INIT  = 16'h0000;
    localparam int          BLK_LEN_DEF = 512;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_FETCH   = 3'd2,
        S_CAPTURE = 3'd3,
        S_SETTLE  = 3'd4,
        S_PRESENT = 3'd5,
        S_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/sd_crc16_byte.sv
// Combinational CRC16-CCITT step over one byte, MSB first.
// Used only when SD_BLK_CRC16_EN is defined.
module sd_crc16_byte
    import sd_blk_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [15:0]       i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [15:0]       o_crc
);

    logic [15:0] w_c;

    always_comb begin
        w_c = i_crc;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            w_c = {w_c[14:0], 1'b0} ^
                  ((w_c[15] ^ i_data[i]) ? CRC16_POLY : 16'h0000);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/sd_blk_fifo_reader.sv
// Drains the SD write-data FIFO into a valid/ready byte stream, one block per start.
// Define SD_BLK_CRC16_EN to accumulate the block CRC16 on crc16.
module sd_blk_fifo_reader
    import sd_blk_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int BLK_LEN = BLK_LEN_DEF,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              fifo_empty,
    output logic              rd_strb,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic              blk_done,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic [15:0]       crc16
);

    state_t            r_state;
    logic              r_rd_strb;
    logic [DATA_W-1:0] r_dout;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_last;

    assign w_last = (r_cnt == CNT_W'(BLK_LEN - 1));

`ifdef SD_BLK_CRC16_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    sd_crc16_byte #(
        .DATA_W (DATA_W)
    ) u_crc (
        .i_crc  (r_crc),
        .i_data (r_dout),
        .o_crc  (w_crc_next)
    );

    assign crc16 = r_crc;
`else
    assign crc16 = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rd_strb <= 1'b0;
            r_dout    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
`ifdef SD_BLK_CRC16_EN
            r_crc     <= CRC16_INIT;
`endif
        end else begin
            r_rd_strb <= 1'b0;
            r_done    <= 1'b0;
            if (abort) begin
                // Abort also beats a same-cycle start; a popped byte is dropped
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state <= S_CHECK;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
`ifdef SD_BLK_CRC16_EN
                            r_crc   <= CRC16_INIT;
`endif
                        end
                    end
                    S_CHECK: begin
                        if (!fifo_empty) begin
                            r_state   <= S_FETCH;
                            r_rd_strb <= 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        r_dout  <= ram_dout;
                        r_state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        // Gives the lagging empty flag time to see this pop
                        r_valid <= 1'b1;
                        r_state <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (dout_ready) begin
                            r_valid <= 1'b0;
                            r_cnt   <= r_cnt + 1'b1;
`ifdef SD_BLK_CRC16_EN
                            r_crc   <= w_crc_next;
`endif
                            if (w_last) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_CHECK;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_strb    = r_rd_strb;
    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign busy       = r_busy;
    assign blk_done   = r_done;
    assign byte_cnt   = r_cnt;

endmodule

// File: tb/tb_sd_blk_fifo_reader.sv
// Bench for sd_blk_fifo_reader: FIFO/RAM environment model plus an in-order byte
// reference queue and a reference CRC16-CCITT over the bytes written.
module tb_sd_blk_fifo_reader;

    localparam int BLK = 512;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        rd_strb;
    logic [7:0]  ram_dout = 8'h00;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        busy;
    logic        blk_done;
    logic [9:0]  byte_cnt;
    logic [15:0] crc16;

    sd_blk_fifo_reader #(
        .DATA_W  (8),
        .BLK_LEN (BLK),
        .CNT_W   (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .fifo_empty (fifo_empty),
        .rd_strb    (rd_strb),
        .ram_dout   (ram_dout),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .blk_done   (blk_done),
        .byte_cnt   (byte_cnt),
        .crc16      (crc16)
    );

    always #5 clk = ~clk;

    // FIFO RAM and address controller environment
    logic [7:0] mem [8192];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    always @(posedge clk) begin
        if (rd_strb) rd_ptr <= rd_ptr + 1;
        fifo_empty <= (wr_ptr == rd_ptr);
        ram_dout   <= mem[rd_ptr % 8192];
    end

    // Stream observer
    int         n_strb = 0;
    int         bad_strb = 0;
    int         bad_stable = 0;
    int         n_done = 0;
    logic       hold = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic [7:0] acc_q [$];

    always @(posedge clk) begin
        if (rd_strb) n_strb <= n_strb + 1;
        if (rd_strb && fifo_empty) bad_strb <= bad_strb + 1;
        if (hold && !reset && (!dout_valid || dout !== hold_d))
            bad_stable <= bad_stable + 1;
        hold   <= dout_valid && !dout_ready && !reset;
        hold_d <= dout;
        if (dout_valid && dout_ready && !reset) acc_q.push_back(dout);
        if (blk_done) n_done <= n_done + 1;
    end

    int         vectors = 0;
    int         errors = 0;
    int         acc_rd = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c,
                                             input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {b, 8'h00};
        for (int k = 0; k < 8; k++)
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 8192] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    task automatic cmp_acc(input string tag, output logic [15:0] crc_m);
        crc_m = 16'h0000;
        while (acc_rd < acc_q.size() && exp_q.size() > 0) begin
            logic [7:0] b;
            b = exp_q.pop_front();
            chk(tag, acc_q[acc_rd], b);
            crc_m = crc_step(crc_m, b);
            acc_rd++;
        end
    endtask

    // mode 0: sink always ready, mode 1: sink ready toggles randomly
    task automatic run_block(input int mode, input bit check_lat,
                             input string tag, output logic [15:0] crc_o);
        int          strb0;
        int          acc0;
        int          done0;
        int          cyc;
        int          lat;
        logic [9:0]  cnt_o;
        logic [15:0] crc_m;
        strb0 = n_strb;
        acc0  = acc_q.size();
        done0 = n_done;
        dout_ready = (mode == 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        if (check_lat) begin
            lat = 0;
            while (!dout_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk({tag, "_latency"}, lat, 4);
        end
        cyc = 0;
        while (!blk_done && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (mode == 1) dout_ready = 1'($urandom_range(0, 1));
            start = (cyc == 60);
        end
        start = 1'b0;
        chk({tag, "_blk_done"}, blk_done, 1);
        cnt_o = byte_cnt;
        crc_o = crc16;
        chk({tag, "_byte_cnt"}, cnt_o, BLK);
        chk({tag, "_strobes"}, n_strb - strb0, BLK);
        chk({tag, "_accepted"}, acc_q.size() - acc0, BLK);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {blk_done, busy}, 2'b00);
        chk({tag, "_done_cnt"}, n_done - done0, 1);
        chk({tag, "_cnt_hold"}, byte_cnt, BLK);
        cmp_acc({tag, "_byte"}, crc_m);
`ifdef SD_BLK_CRC16_EN
        chk({tag, "_crc"}, crc_o, crc_m);
`else
        chk({tag, "_crc"}, crc_o, 16'h0000);
`endif
    endtask

    initial begin
        logic [15:0] crc_o;
        logic [15:0] crc_d;
        int          strb0;
        int          acc0;
        int          done0;
        int          cyc;

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {rd_strb, dout, dout_valid, busy, blk_done, byte_cnt, crc16}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Preloaded incrementing pattern
        for (int i = 0; i < BLK; i++) push(8'(i));
        repeat (3) @(negedge clk);
        run_block(0, 1'b1, "incr", crc_o);

        // Empty FIFO trickle-filled every 20 cycles
        fork
            begin
                for (int i = 0; i < BLK; i++) begin
                    repeat (20) @(negedge clk);
                    push(8'($urandom));
                end
            end
            run_block(0, 1'b0, "trickle", crc_o);
        join
        chk("trickle_strb_empty", bad_strb, 0);

        // Random backpressure
        for (int i = 0; i < BLK; i++) push(8'($urandom));
        repeat (3) @(negedge clk);
        run_block(1, 1'b0, "bp", crc_o);
        chk("bp_stable", bad_stable, 0);

        // Abort after 100 accepted bytes
        for (int i = 0; i < BLK + 100; i++) push(8'($urandom));
        repeat (3) @(negedge clk);
        strb0 = n_strb;
        acc0  = acc_q.size();
        done0 = n_done;
        dout_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (acc_q.size() - acc0 < 100 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", {busy, dout_valid, blk_done, rd_strb}, 4'b0000);
        chk("abort_cnt", byte_cnt, 100);
        repeat (10) @(negedge clk);
        chk("abort_strobes", n_strb - strb0, 100);
        chk("abort_no_done", n_done - done0, 0);
        chk("abort_idle", busy, 0);
        cmp_acc("abort_byte", crc_d);
        run_block(0, 1'b0, "resume", crc_o);

        // Start and abort together while idle
        for (int i = 0; i < BLK; i++) push(8'hFF);
        repeat (3) @(negedge clk);
        strb0 = n_strb;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        repeat (8) @(negedge clk);
        chk("start_abort_strobes", n_strb - strb0, 0);

        // All-0xFF block: known CRC
        run_block(0, 1'b0, "ones", crc_o);
`ifdef SD_BLK_CRC16_EN
        chk("ones_crc_const", crc_o, 16'h7FA1);
`else
        chk("ones_crc_zero", crc_o, 16'h0000);
`endif

        // Asynchronous reset while a byte is presented
        for (int i = 0; i < 5; i++) push(8'($urandom));
        repeat (3) @(negedge clk);
        dout_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!dout_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("present_reached", dout_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset",
            {rd_strb, dout, dout_valid, busy, blk_done, byte_cnt, crc16}, 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < BLK - 4; i++) push(8'($urandom));
        repeat (3) @(negedge clk);
        run_block(0, 1'b0, "post_reset", crc_o);

        chk("final_strb_empty", bad_strb, 0);
        chk("final_stable", bad_stable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
